// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one carry-select adder between two requesters.
// Optional grant statistics enabled by defining ADDER_ARB_STATS_EN.
module N_bitadder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         cout
);
   localparam int H = N / 2;

   logic [H:0] lo;
   logic [H:0] hi0;
   logic [H:0] hi1;

   // Upper half is computed for both carry-in values and selected late.
   assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
   assign hi0 = {1'b0, a[N-1:H]} + {1'b0, b[N-1:H]};
   assign hi1 = hi0 + {{H{1'b0}}, 1'b1};

   assign s    = {lo[H] ? hi1[H-1:0] : hi0[H-1:0], lo[H-1:0]};
   assign cout = lo[H] ? hi1[H] : hi0[H];
endmodule

module adder_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_sum,
   output logic         rsp_cout,
   output logic         rsp_id,
   output logic [15:0]  grant_cnt0,
   output logic [15:0]  grant_cnt1
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state;
   state_t       state_nxt;
   logic         prio;
   logic         gnt0;
   logic         gnt1;
   logic         acc0;
   logic         acc1;
   logic         acc;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         op_id;
   logic [N-1:0] add_s;
   logic         add_c;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case ({req1_valid, req0_valid})
         2'b01:   gnt0 = 1'b1;
         2'b10:   gnt1 = 1'b1;
         2'b11: begin
            gnt0 = ~prio;
            gnt1 = prio;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (acc) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!rst && state == IDLE) begin
         acc0 = gnt0;
         acc1 = gnt1;
      end
      acc = acc0 | acc1;
   end

   assign req0_ready = acc0;
   assign req1_ready = acc1;

   N_bitadder #(.N(N)) u_add (
      .a    (op_a),
      .b    (op_b),
      .s    (add_s),
      .cout (add_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= 1'b0;
         prio      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         if (acc) begin
            op_a  <= acc1 ? req1_a : req0_a;
            op_b  <= acc1 ? req1_b : req0_b;
            op_id <= acc1;
            prio  <= ~acc1;
         end
         if (state == EXEC) begin
            rsp_sum   <= add_s;
            rsp_cout  <= add_c;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ADDER_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (acc0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (acc1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a
// transaction-level model of arbitration, timing and arithmetic.
module tb_adder_arbiter;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_sum;
   logic         rsp_cout;
   logic         rsp_id;
   logic [15:0]  grant_cnt0;
   logic [15:0]  grant_cnt1;

   int  checks   = 0;
   int  failures = 0;
   int  last_id  = 1;
   int  cnt0     = 0;
   int  cnt1     = 0;
   time acc_t;

   adder_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_stats();
`ifdef ADDER_ARB_STATS_EN
      check("cnt0", grant_cnt0, cnt0);
      check("cnt1", grant_cnt1, cnt1);
`else
      check("cnt0", grant_cnt0, 0);
      check("cnt1", grant_cnt1, 0);
`endif
   endtask

   // One transaction from the IDLE point (#1 after an edge) back to IDLE.
   task automatic txn(input bit v0, input bit v1,
                      input logic [N-1:0] a0, input logic [N-1:0] b0,
                      input logic [N-1:0] a1, input logic [N-1:0] b1,
                      input int stall);
      int         id;
      logic [N:0] full;
      id   = (v0 && v1) ? 1 - last_id : (v0 ? 0 : 1);
      full = (id == 0) ? {1'b0, a0} + {1'b0, b0} : {1'b0, a1} + {1'b0, b1};
      req0_valid = v0;
      req1_valid = v1;
      req0_a = a0; req0_b = b0;
      req1_a = a1; req1_b = b1;
      rsp_ready = (stall == 0);
      #1;
      check("grant", {req1_ready, req0_ready}, (id == 0) ? 2'b01 : 2'b10);
      check("idle_rspv", rsp_valid, 0);
      @(posedge clk);
      acc_t   = $time;
      last_id = id;
      if (id == 0) cnt0++; else cnt1++;
      #1;
      check("exec_ready", {req1_ready, req0_ready}, 0);
      check("exec_rspv", rsp_valid, 0);
      @(posedge clk); #1;
      check("rspv", rsp_valid, 1);
      check("sum", rsp_sum, full[N-1:0]);
      check("cout", rsp_cout, full[N]);
      check("id", rsp_id, id);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("hold_rspv", rsp_valid, 1);
         check("hold_sum", rsp_sum, full[N-1:0]);
         check("hold_id", rsp_id, id);
         check("hold_ready", {req1_ready, req0_ready}, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("done_rspv", rsp_valid, 0);
      check("done_sum", rsp_sum, full[N-1:0]);
      check_stats();
   endtask

   initial begin
      time t[4];
      bit  v0, v1;
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rspv", rsp_valid, 0);
      check("rst_sum", rsp_sum, 0);
      check("rst_cout", rsp_cout, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ready", {req1_ready, req0_ready}, 0);
      check_stats();
      req0_valid = 1; req1_valid = 1;
      #1 check("rst_force_ready", {req1_ready, req0_ready}, 0);
      req0_valid = 0; req1_valid = 0;
      #2 rst = 1'b0;
      @(posedge clk); #1;

      txn(1, 0, 432, 5345, 0, 0, 0);
      txn(1, 0, 32'h0000FFFF, 1, 0, 0, 0);
      txn(0, 1, 0, 0, 32'hFFFFFFFF, 1, 0);
      txn(0, 1, 0, 0, 234234, 321423, 0);

      // Fairness: prio now points at requester 0 after a req1 grant.
      for (int i = 0; i < 4; i++) begin
         txn(1, 1, $urandom, $urandom, $urandom, $urandom, 0);
         t[i] = acc_t;
         check("fair_id", rsp_id, i % 2);
      end
      for (int i = 1; i < 4; i++) check("spacing", t[i] - t[i-1], 30);

      txn(1, 1, $urandom, $urandom, $urandom, $urandom, 5);
      txn(1, 1, $urandom, $urandom, $urandom, $urandom, 0);

      // Mid-op reset with a req1 result pending.
      req0_valid = 0; req1_valid = 1;
      req1_a = 7; req1_b = 9; rsp_ready = 0;
      @(posedge clk);
      @(posedge clk); #1;
      check("mid_rspv_pre", rsp_valid, 1);
      check("mid_id_pre", rsp_id, 1);
      #2 rst = 1'b1;
      req0_valid = 1;
      #1;
      check("mid_rspv", rsp_valid, 0);
      check("mid_ready", {req1_ready, req0_ready}, 0);
      last_id = 1; cnt0 = 0; cnt1 = 0;
      @(posedge clk); #1 rst = 1'b0;
      txn(1, 1, $urandom, $urandom, $urandom, $urandom, 0);
      check("mid_first", rsp_id, 0);

      for (int i = 0; i < 40; i++) begin
         v0 = 1'($urandom);
         v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1;
         txn(v0, v1, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 3));
      end

      req0_valid = 0; req1_valid = 0;
      #1 check("final_ready", {req1_ready, req0_ready}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
